// File: rtl/fp_add_arbiter.sv
// ============================================================================
// Module   : fp_add_arbiter
// Purpose  : Round-robin sharing of one combinational FP32 adder among NUM_REQ
//            requesters through a two-stage (operand / result) pipeline.
// Options  : define STICKY_FLAGS_EN to add sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [3*NUM_REQ-1:0]   req_rmode,
  output logic [31:0]            add_fp_a,
  output logic [31:0]            add_fp_b,
  output logic [2:0]             add_r_mode,
  input  logic [31:0]            add_fp_result,
  input  logic                   add_overflow,
  input  logic                   add_underflow,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_result,
  output logic                   rsp_overflow,
  output logic                   rsp_underflow,
  input  logic                   flag_clear,
  output logic                   flag_ovf,
  output logic                   flag_unf
);

  localparam int              PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  // Pipeline and arbitration state
  logic             s1_valid_q, s1_valid_d;
  logic [PTR_W-1:0] s1_id_q, s1_id_d;
  logic [31:0]      s1_a_q, s1_a_d;
  logic [31:0]      s1_b_q, s1_b_d;
  logic [2:0]       s1_rmode_q, s1_rmode_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_unf_q, rsp_unf_d;

  // Combinational arbitration signals
  logic             s2_load;
  logic             s1_load;
  logic             any_valid;
  logic             accept;
  logic             found_hi;
  logic             found_lo;
  logic [PTR_W-1:0] idx_hi;
  logic [PTR_W-1:0] idx_lo;
  logic [PTR_W-1:0] grant_idx;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [2:0]       sel_rmode;

  assign s2_load   = s1_valid_q && (!rsp_valid_q || rsp_ready);
  assign s1_load   = !s1_valid_q || s2_load;
  assign any_valid = |req_valid;
  assign accept    = s1_load && any_valid && !rst;

  // Round-robin search split in two passes: indices at or above the pointer
  // win first, otherwise the lowest valid index (the wrap-around case).
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = PTR_W'(i);
      end
      if (req_valid[i] && !found_hi && (PTR_W'(i) >= rr_ptr_q)) begin
        found_hi = 1'b1;
        idx_hi   = PTR_W'(i);
      end
    end
    grant_idx = found_hi ? idx_hi : idx_lo;
  end

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_rmode = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        req_ready[i] = accept;
        sel_a        = req_a[32*i +: 32];
        sel_b        = req_b[32*i +: 32];
        sel_rmode    = req_rmode[3*i +: 3];
      end
    end
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_id_d      = s1_id_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_rmode_d   = s1_rmode_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_unf_d    = rsp_unf_q;

    // An empty load slot drops s1_valid but keeps the adder operands steady.
    if (s1_load) begin
      s1_valid_d = any_valid;
      if (any_valid) begin
        s1_id_d    = grant_idx;
        s1_a_d     = sel_a;
        s1_b_d     = sel_b;
        s1_rmode_d = sel_rmode;
        rr_ptr_d   = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
      end
    end

    if (s2_load) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = ID_W'(s1_id_q);
      rsp_result_d = add_fp_result;
      rsp_ovf_d    = add_overflow;
      rsp_unf_d    = add_underflow;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_rmode_q   <= '0;
      rr_ptr_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_unf_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_rmode_q   <= s1_rmode_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_unf_q    <= rsp_unf_d;
    end
  end

  assign add_fp_a      = s1_a_q;
  assign add_fp_b      = s1_b_q;
  assign add_r_mode    = s1_rmode_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_overflow  = rsp_ovf_q;
  assign rsp_underflow = rsp_unf_q;

`ifdef STICKY_FLAGS_EN
  logic rsp_pop;
  logic flag_ovf_q, flag_ovf_d;
  logic flag_unf_q, flag_unf_d;

  assign rsp_pop = rsp_valid_q && rsp_ready;

  // A flag event in the same cycle as a clear keeps the flag set.
  always_comb begin
    flag_ovf_d = flag_clear ? 1'b0 : flag_ovf_q;
    flag_unf_d = flag_clear ? 1'b0 : flag_unf_q;
    if (rsp_pop && rsp_ovf_q) flag_ovf_d = 1'b1;
    if (rsp_pop && rsp_unf_q) flag_unf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_ovf_q <= 1'b0;
      flag_unf_q <= 1'b0;
    end else begin
      flag_ovf_q <= flag_ovf_d;
      flag_unf_q <= flag_unf_d;
    end
  end

  assign flag_ovf = flag_ovf_q;
  assign flag_unf = flag_unf_q;
`else
  logic unused_flag_clear;
  assign unused_flag_clear = flag_clear;
  assign flag_ovf          = 1'b0;
  assign flag_unf          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
// ============================================================================
// Module   : tb_fp_add_arbiter
// Purpose  : Scoreboard bench for fp_add_arbiter with a stand-in adder model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_add_arbiter;

  localparam int N  = 4;
  localparam int IW = 3;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          ovf;
    logic          unf;
    logic [31:0]   res;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [3*N-1:0]  req_rmode;
  logic [31:0]     add_fp_a;
  logic [31:0]     add_fp_b;
  logic [2:0]      add_r_mode;
  logic [31:0]     add_fp_result;
  logic            add_overflow;
  logic            add_underflow;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_overflow;
  logic            rsp_underflow;
  logic            flag_clear;
  logic            flag_ovf;
  logic            flag_unf;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t mon_exp;
  exp_t mon_got;
  exp_t mon_new;

  // Stand-in adder: exact for the directed IEEE vectors, a deterministic
  // mixing function otherwise so operand/id routing is still observable.
  function automatic logic [33:0] fp_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] rm);
    logic [31:0] r;
    if (a == 32'h3F80_0000 && b == 32'h3F80_0000) return {2'b00, 32'h4000_0000};
    if (a == 32'h7F7F_FFFF && b == 32'h7F7F_FFFF && rm == 3'b000)
      return {2'b10, 32'h7F80_0000};
    r = a + b + {29'd0, rm};
    return {(r[31:28] == 4'hF), (r[30:23] == 8'h00), r};
  endfunction

  logic [33:0] add_out;
  assign add_out       = fp_model(add_fp_a, add_fp_b, add_r_mode);
  assign add_overflow  = add_out[33];
  assign add_underflow = add_out[32];
  assign add_fp_result = add_out[31:0];

  fp_add_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rmode(req_rmode),
    .add_fp_a(add_fp_a), .add_fp_b(add_fp_b), .add_r_mode(add_r_mode),
    .add_fp_result(add_fp_result), .add_overflow(add_overflow),
    .add_underflow(add_underflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_underflow(rsp_underflow),
    .flag_clear(flag_clear), .flag_ovf(flag_ovf), .flag_unf(flag_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: pop on response handshake, push on request handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        mon_got = {rsp_id, rsp_overflow, rsp_underflow, rsp_result};
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got id=%0d res=%h, required no response", rsp_id, rsp_result);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_got !== mon_exp)
            begin
              n_fail++;
              $display("FAIL sb_response: got id=%0d ovf=%b unf=%b res=%h, required id=%0d ovf=%b unf=%b res=%h",
                       mon_got.id, mon_got.ovf, mon_got.unf, mon_got.res,
                       mon_exp.id, mon_exp.ovf, mon_exp.unf, mon_exp.res);
            end
        end
      end
      n_checks++;
      if ($countones(req_ready) > 1) begin
        n_fail++;
        $display("FAIL ready_onehot: got req_ready=%b, required at most one bit", req_ready);
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          mon_new.id = IW'(i);
          {mon_new.ovf, mon_new.unf, mon_new.res} =
            fp_model(req_a[32*i +: 32], req_b[32*i +: 32], req_rmode[3*i +: 3]);
          sb.push_back(mon_new);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rm);
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
    req_rmode[3*i +: 3] = rm;
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0 && !rsp_valid) break;
      step();
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || add_fp_a !== 32'd0 || add_fp_b !== 32'd0 ||
        add_r_mode !== 3'd0 || rsp_result !== 32'd0 || rsp_id !== 3'd0 ||
        rsp_overflow !== 1'b0 || rsp_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b rv=%b a=%h res=%h id=%0d, required all zero",
               req_ready, rsp_valid, add_fp_a, rsp_result, rsp_id);
    end
    step();
    req_valid = '0;
    rst       = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || flag_ovf !== 1'b0 || flag_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rv=%b fo=%b fu=%b, required 0 0 0", rsp_valid, flag_ovf, flag_unf);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++)
      set_req(i, 32'h4000_0000 + 32'(i * 16), 32'h0000_0100 + 32'(i), 3'(i));
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_rdy = 4'b0001 << (k % N);
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %b, required %b", k, req_ready, exp_rdy);
      end
      step();
    end
    req_valid = '0;
    drain();
  endtask

  task automatic test_single();
    set_req(0, 32'h3F80_0000, 32'h3F80_0000, 3'b000);
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ready: got %b, required 0001", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || add_fp_a !== 32'h3F80_0000 || add_fp_b !== 32'h3F80_0000 ||
        add_r_mode !== 3'b000) begin
      n_fail++;
      $display("FAIL single_s1: got rv=%b a=%h b=%h, required 0 3f800000 3f800000", rsp_valid, add_fp_a, add_fp_b);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'h4000_0000 || rsp_id !== 3'd0 ||
        rsp_overflow !== 1'b0 || rsp_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp: got rv=%b res=%h id=%0d, required 1 40000000 0", rsp_valid, rsp_result, rsp_id);
    end
    step();
    drain();
  endtask

  task automatic test_stall();
    logic [N-1:0] exp_rdy[5];
    logic [N-1:0] acc;
    logic [31:0]  held_res;
    exp_rdy = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    held_res = '0;
    set_req(1, 32'h3F80_0000, 32'h4000_0000, 3'b001);
    set_req(2, 32'h1234_5678, 32'h0101_0101, 3'b010);
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      acc = req_ready & req_valid;
      n_checks++;
      if (req_ready !== exp_rdy[k]) begin
        n_fail++;
        $display("FAIL stall_ready[%0d]: got %b, required %b", k, req_ready, exp_rdy[k]);
      end
      if (k == 2) held_res = rsp_result;
      if (k >= 2) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || rsp_result !== held_res) begin
          n_fail++;
          $display("FAIL stall_hold[%0d]: got rv=%b id=%0d res=%h, required 1 1 %h",
                   k, rsp_valid, rsp_id, rsp_result, held_res);
        end
      end
      step();
      req_valid = req_valid & ~acc;
    end
    rsp_ready = 1'b1;
    drain();
  endtask

  task automatic test_overflow();
    set_req(0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 3'b000);
    req_valid = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL ovf_ready: got %b, required 0001", req_ready);
    end
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'h7F80_0000 || rsp_overflow !== 1'b1 ||
        rsp_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_rsp: got rv=%b res=%h ovf=%b, required 1 7f800000 1", rsp_valid, rsp_result, rsp_overflow);
    end
    step();
    step();
    @(negedge clk);
    n_checks++;
`ifdef STICKY_FLAGS_EN
    if (flag_ovf !== 1'b1 || flag_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_sticky: got fo=%b fu=%b, required 1 0", flag_ovf, flag_unf);
    end
`else
    if (flag_ovf !== 1'b0 || flag_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_noflags: got fo=%b fu=%b, required 0 0", flag_ovf, flag_unf);
    end
`endif
    step();
    flag_clear = 1'b1;
    step();
    flag_clear = 1'b0;
    @(negedge clk);
    n_checks++;
    if (flag_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got fo=%b, required 0", flag_ovf);
    end
    step();
    drain();
  endtask

  task automatic test_rr_wrap();
    set_req(2, 32'h0000_0010, 32'h0000_0020, 3'b011);
    req_valid = 4'b0100;
    @(negedge clk);
    step();
    req_valid = 4'b0000;
    set_req(0, 32'h0000_0100, 32'h0000_0200, 3'b100);
    req_valid = 4'b0101;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_first: got %b, required 0001", req_ready);
    end
    step();
    req_valid = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL wrap_second: got %b, required 0100", req_ready);
    end
    step();
    req_valid = '0;
    drain();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    @(negedge clk);
    step();
    req_valid = 4'b0010;
    @(negedge clk);
    step();
    req_valid = 4'b1111;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL full_stall: got rv=%b ready=%b, required 1 0000", rsp_valid, req_ready);
    end
    step();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || rsp_result !== 32'd0 || rsp_id !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got rv=%b ready=%b res=%h id=%0d, required 0 0000 0 0",
               rsp_valid, req_ready, rsp_result, rsp_id);
    end
    step();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    set_req(3, 32'h0000_0003, 32'h0000_0004, 3'b000);
    req_valid = 4'b1001;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL ptr_after_reset: got %b, required 0001", req_ready);
    end
    step();
    req_valid = 4'b1000;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL req3_alone: got %b, required 1000", req_ready);
    end
    step();
    req_valid = '0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 4'b1111;
    req_a      = '0;
    req_b      = '0;
    req_rmode  = '0;
    rsp_ready  = 1'b1;
    flag_clear = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_stall();
    test_overflow();
    test_rr_wrap();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL final_empty: got %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
